// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the bus generator/arbiter.
// Optional macro BCAST_SELF_EN: broadcasts are also pushed back to the source.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    ARB,
    POP,
    PUSH
  } state_t;

  localparam int unsigned MAX_W = 64;

  function automatic logic [MAX_W-1:0] get_id(
    input logic [MAX_W-1:0] pkt,
    input int unsigned      pkt_sz,
    input int unsigned      id_w
  );
    logic [MAX_W-1:0] mask;
    mask = (MAX_W'(1) << id_w) - MAX_W'(1);
    return (pkt >> (pkt_sz - id_w)) & mask;
  endfunction

  function automatic logic is_valid_dest(
    input logic [MAX_W-1:0] id,
    input int unsigned      drvrs,
    input int unsigned      bcast
  );
    return (id < MAX_W'(drvrs)) || (id == MAX_W'(bcast));
  endfunction

endpackage

// File: rtl/bus_generator_arbiter_rr.sv
// Combinational round-robin pick: first request at or after ptr_i, wrapping.
// Also built under BCAST_SELF_EN unchanged.
module rr_arbiter #(
  parameter int unsigned N  = 16,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [PW-1:0] gnt_idx_o,
  output logic          gnt_vld_o
);

  always_comb begin
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    // Walk backwards so the closest request to ptr_i wins last.
    for (int i = N - 1; i >= 0; i--) begin
      int k;
      k = (int'(ptr_i) + i) % int'(N);
      if (req_i[k]) begin
        gnt_idx_o = PW'(k);
        gnt_vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_generator_arbiter.sv
// Shared-bus generator/arbiter: round-robin pop, then unicast/broadcast push.
// Macro BCAST_SELF_EN: broadcast push includes the source device.
module bus_generator_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned DRVRS     = 16,
  parameter int unsigned PCKG_SZ   = 16,
  parameter int unsigned ID_W      = 8,
  parameter int unsigned BROADCAST = 145
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DRVRS-1:0]         pndng,
  input  logic [DRVRS*PCKG_SZ-1:0] D_pop,
  output logic [DRVRS-1:0]         pop,
  output logic [DRVRS-1:0]         push,
  output logic [PCKG_SZ-1:0]       D_push
);

  localparam int unsigned PW = $clog2(DRVRS);
  localparam logic [MAX_W-1:0] BC_ID = MAX_W'(BROADCAST);

  state_t               state_q, state_d;
  logic [PW-1:0]        gnt_q, gnt_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [PCKG_SZ-1:0]   pkt_q, pkt_d;
  logic [DRVRS-1:0]     pop_q, pop_d;
  logic [DRVRS-1:0]     push_q, push_d;

  logic [PW-1:0]        gnt_idx;
  logic                 gnt_vld;
  logic [PCKG_SZ-1:0]   head;
  logic [MAX_W-1:0]     dest;
  logic [DRVRS-1:0]     bcast_mask;

  rr_arbiter #(
    .N  (DRVRS),
    .PW (PW)
  ) u_rr (
    .req_i     (pndng),
    .ptr_i     (ptr_q),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  assign head = D_pop[gnt_q*PCKG_SZ +: PCKG_SZ];
  assign dest = get_id(MAX_W'(head), PCKG_SZ, ID_W);

`ifdef BCAST_SELF_EN
  assign bcast_mask = '1;
`else
  assign bcast_mask = ~(DRVRS'(1) << gnt_q);
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    pkt_d   = pkt_q;
    pop_d   = '0;
    push_d  = '0;
    unique case (state_q)
      ARB: begin
        if (gnt_vld) begin
          gnt_d   = gnt_idx;
          pop_d   = DRVRS'(1) << gnt_idx;
          state_d = POP;
        end
      end
      POP: begin
        // Head data is valid before the pop, so route it now.
        pkt_d   = head;
        state_d = PUSH;
        if (is_valid_dest(dest, DRVRS, BROADCAST)) begin
          if (dest == BC_ID) push_d = bcast_mask;
          else               push_d = DRVRS'(1) << dest;
        end
      end
      PUSH: begin
        pkt_d   = '0;
        ptr_d   = (gnt_q == PW'(DRVRS - 1)) ? '0 : gnt_q + PW'(1);
        state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARB;
      gnt_q   <= '0;
      ptr_q   <= '0;
      pkt_q   <= '0;
      pop_q   <= '0;
      push_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      pkt_q   <= pkt_d;
      pop_q   <= pop_d;
      push_q  <= push_d;
    end
  end

  assign pop    = pop_q;
  assign push   = push_q;
  assign D_push = pkt_q;

endmodule

// File: tb/tb_bus_generator_arbiter.sv
// Directed bench for bus_generator_arbiter with 4 devices.
// Honours BCAST_SELF_EN for the broadcast expectation.
module tb_bus_generator_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  pndng;
  logic [63:0] d_pop;
  logic [3:0]  pop;
  logic [3:0]  push;
  logic [15:0] d_push;

  int nvec;
  int nerr;

  bus_generator_arbiter #(
    .DRVRS     (4),
    .PCKG_SZ   (16),
    .ID_W      (8),
    .BROADCAST (145)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .pndng  (pndng),
    .D_pop  (d_pop),
    .pop    (pop),
    .push   (push),
    .D_push (d_push)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nedge();
    @(negedge clk);
  endtask

  task automatic set_slot(input int i, input logic [15:0] v);
    d_pop[i*16 +: 16] = v;
  endtask

  initial begin
    logic [3:0] bc_exp;
    logic [3:0] rr_exp;
    nvec  = 0;
    nerr  = 0;
    reset = 1'b0;
    pndng = 4'b0000;
    d_pop = '0;
`ifdef BCAST_SELF_EN
    bc_exp = 4'b1111;
`else
    bc_exp = 4'b1110;
`endif

    nedge();
    nedge();
    chk("rst_pop", 16'(pop), 16'h0000);
    chk("rst_push", 16'(push), 16'h0000);
    chk("rst_dpush", d_push, 16'h0000);

    reset = 1'b1;
    nedge();
    nedge();
    chk("idle_pop", 16'(pop), 16'h0000);
    chk("idle_push", 16'(push), 16'h0000);

    // unicast 2 -> 1
    set_slot(2, 16'h01AB);
    pndng = 4'b0100;
    nedge();
    chk("uni_pop", 16'(pop), 16'h0004);
    chk("uni_push0", 16'(push), 16'h0000);
    pndng = 4'b0000;
    nedge();
    chk("uni_pop_off", 16'(pop), 16'h0000);
    chk("uni_push", 16'(push), 16'h0002);
    chk("uni_dpush", d_push, 16'h01AB);
    nedge();
    chk("uni_done", 16'(push), 16'h0000);

    // broadcast from 0 (ptr is 3, wraps to 0)
    set_slot(0, 16'h9155);
    pndng = 4'b0001;
    nedge();
    chk("bc_pop", 16'(pop), 16'h0001);
    pndng = 4'b0000;
    nedge();
    chk("bc_push", 16'(push), 16'(bc_exp));
    chk("bc_dpush", d_push, 16'h9155);
    nedge();
    chk("bc_done", 16'(push), 16'h0000);

    // invalid destination from 3
    set_slot(3, 16'h0733);
    pndng = 4'b1000;
    nedge();
    chk("inv_pop", 16'(pop), 16'h0008);
    chk("inv_push0", 16'(push), 16'h0000);
    pndng = 4'b0000;
    nedge();
    chk("inv_push", 16'(push), 16'h0000);
    chk("inv_pop_off", 16'(pop), 16'h0000);
    nedge();
    chk("inv_done", 16'(push), 16'h0000);

    // round robin, ptr back at 0
    set_slot(0, 16'h0212);
    set_slot(1, 16'h0300);
    set_slot(2, 16'h0000);
    set_slot(3, 16'h0101);
    pndng = 4'b1111;
    for (int k = 0; k < 13; k++) begin
      nedge();
      case (k)
        0, 12:   rr_exp = 4'b0001;
        3:       rr_exp = 4'b0010;
        6:       rr_exp = 4'b0100;
        9:       rr_exp = 4'b1000;
        default: rr_exp = 4'b0000;
      endcase
      chk($sformatf("rr_pop%0d", k), 16'(pop), 16'(rr_exp));
    end
    pndng = 4'b0000;
    nedge();
    chk("rr_push", 16'(push), 16'h0004);
    chk("rr_dpush", d_push, 16'h0212);

    // asynchronous reset in PUSH
    reset = 1'b0;
    #1;
    chk("mid_push", 16'(push), 16'h0000);
    chk("mid_dpush", d_push, 16'h0000);
    chk("mid_pop", 16'(pop), 16'h0000);
    nedge();
    reset = 1'b1;
    pndng = 4'b1111;
    nedge();
    chk("post_rst_pop", 16'(pop), 16'h0001);
    pndng = 4'b0000;
    nedge();
    chk("post_rst_push", 16'(push), 16'h0004);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
